// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: single-car SCAN controller. Hall and car calls are
// latched into pending registers and served in the current travel direction.
// The car reverses only when nothing is pending ahead of it.
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_IDLE      | parked with door closed, direction STOP
// S_DOOR_OPEN | door open at currentFloor, dwell timer running
// S_MOVING    | travelling, one floor per CLK_DELAY_MOVE cycles
module elevator_scan_ctrl #(
   parameter int FLOORS         = 7,
   parameter int CLK_DELAY_OPEN = 500000000,
   parameter int CLK_DELAY_MOVE = 1000000000
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [FLOORS-1:0] hallUp_i,
   input  logic [FLOORS-1:0] hallDown_i,
   input  logic [FLOORS-1:0] carCall_i,
   input  logic              doorHold_i,
   output logic [3:0]        currentFloor_o,
   output logic [1:0]        direction_o,
   output logic              doorState_o,
   output logic              move_o,
   output logic [FLOORS-1:0] pendingUp_o,
   output logic [FLOORS-1:0] pendingDown_o,
   output logic [FLOORS-1:0] pendingCar_o
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_DOOR_OPEN = 2'd1,
      S_MOVING    = 2'd2
   } state_t;

   localparam logic [1:0]        DIR_STOP = 2'b00;
   localparam logic [1:0]        DIR_UP   = 2'b10;
   localparam logic [1:0]        DIR_DOWN = 2'b01;
   localparam logic [31:0]       OPEN_TC  = 32'(CLK_DELAY_OPEN - 1);
   localparam logic [31:0]       MOVE_TC  = 32'(CLK_DELAY_MOVE - 1);
   localparam logic [3:0]        TOP_FLR  = 4'(FLOORS);
   // top floor has no up call, bottom floor has no down call
   localparam logic [FLOORS-1:0] UP_OK    = {1'b0, {(FLOORS-1){1'b1}}};
   localparam logic [FLOORS-1:0] DN_OK    = {{(FLOORS-1){1'b1}}, 1'b0};

   function automatic logic [FLOORS-1:0] floor_bit(input logic [3:0] fl);
      logic [FLOORS-1:0] m;
      m = '0;
      for (int i = 0; i < FLOORS; i++) begin
         if (int'(fl) == i + 1) m[i] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic any_above(input logic [FLOORS-1:0] v, input logic [3:0] fl);
      logic r;
      r = 1'b0;
      for (int i = 0; i < FLOORS; i++) begin
         if (i + 1 > int'(fl)) r = r | v[i];
      end
      return r;
   endfunction

   function automatic logic any_below(input logic [FLOORS-1:0] v, input logic [3:0] fl);
      logic r;
      r = 1'b0;
      for (int i = 0; i < FLOORS; i++) begin
         if (i + 1 < int'(fl)) r = r | v[i];
      end
      return r;
   endfunction

   // keep going while work remains ahead, else turn around, else stop;
   // a parked car prefers UP
   function automatic logic [1:0] pick_dir(input logic [1:0] cur, input logic a, input logic b);
      logic [1:0] d;
      if (cur == DIR_DOWN) d = b ? DIR_DOWN : (a ? DIR_UP : DIR_STOP);
      else                 d = a ? DIR_UP   : (b ? DIR_DOWN : DIR_STOP);
      return d;
   endfunction

   state_t            state_q, state_d;
   logic [3:0]        floor_q, floor_d;
   logic [1:0]        dir_q, dir_d;
   logic [31:0]       timer_q, timer_d;
   logic [FLOORS-1:0] pend_up_q, pend_up_d;
   logic [FLOORS-1:0] pend_dn_q, pend_dn_d;
   logic [FLOORS-1:0] pend_car_q, pend_car_d;

   logic [FLOORS-1:0] up_in, dn_in, all_q, cur_bit, next_bit;
   logic [FLOORS-1:0] clr_up, clr_dn, clr_car, abs_up, abs_dn, abs_car;
   logic [3:0]        next_floor;
   logic [1:0]        new_dir;
   logic              above, below, ahead_nf, hit_car, hit_dir, hit_opp, reversal;

   assign up_in      = hallUp_i & UP_OK;
   assign dn_in      = hallDown_i & DN_OK;
   assign all_q      = pend_up_q | pend_dn_q | pend_car_q;
   assign cur_bit    = floor_bit(floor_q);
   assign above      = any_above(all_q, floor_q);
   assign below      = any_below(all_q, floor_q);
   assign next_floor = (dir_q == DIR_DOWN) ? floor_q - 4'd1 : floor_q + 4'd1;
   assign next_bit   = floor_bit(next_floor);
   assign ahead_nf   = (dir_q == DIR_UP) ? any_above(all_q, next_floor)
                                         : any_below(all_q, next_floor);
   assign hit_car    = |(pend_car_q & next_bit);
   assign hit_dir    = |(((dir_q == DIR_UP) ? pend_up_q : pend_dn_q) & next_bit);
   assign hit_opp    = |(((dir_q == DIR_UP) ? pend_dn_q : pend_up_q) & next_bit);
   assign reversal   = hit_opp & ~ahead_nf & ~hit_dir;

   // state, position, timer and pending registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         floor_q    <= 4'd1;
         dir_q      <= DIR_STOP;
         timer_q    <= '0;
         pend_up_q  <= '0;
         pend_dn_q  <= '0;
         pend_car_q <= '0;
      end else begin
         state_q    <= state_d;
         floor_q    <= floor_d;
         dir_q      <= dir_d;
         timer_q    <= timer_d;
         pend_up_q  <= pend_up_d;
         pend_dn_q  <= pend_dn_d;
         pend_car_q <= pend_car_d;
      end
   end

   // next-state, timer and request clear/latch decisions
   always_comb begin
      state_d = state_q;
      floor_d = floor_q;
      dir_d   = dir_q;
      timer_d = timer_q;
      clr_up  = '0;
      clr_dn  = '0;
      clr_car = '0;
      abs_up  = '0;
      abs_dn  = '0;
      abs_car = '0;
      new_dir = DIR_STOP;
      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            dir_d   = DIR_STOP;
            if (|(all_q & cur_bit)) begin
               state_d = S_DOOR_OPEN;
               clr_car = cur_bit;
               if (|(pend_up_q & cur_bit)) begin
                  clr_up = cur_bit;
                  dir_d  = DIR_UP;
               end else if (|(pend_dn_q & cur_bit)) begin
                  clr_dn = cur_bit;
                  dir_d  = DIR_DOWN;
               end else begin
                  // car call only: face away from the end stop
                  dir_d = (floor_q == TOP_FLR) ? DIR_DOWN : DIR_UP;
               end
            end else if (above || below) begin
               state_d = S_MOVING;
               dir_d   = pick_dir(DIR_STOP, above, below);
            end
         end
         S_MOVING: begin
            if (timer_q == MOVE_TC) begin
               timer_d = '0;
               floor_d = next_floor;
               if (hit_car || hit_dir || !ahead_nf) begin
                  state_d = S_DOOR_OPEN;
                  clr_car = next_bit;
                  if (dir_q == DIR_UP) clr_up = next_bit;
                  else                 clr_dn = next_bit;
                  if (reversal) begin
                     if (dir_q == DIR_UP) begin
                        clr_dn = next_bit;
                        dir_d  = DIR_DOWN;
                     end else begin
                        clr_up = next_bit;
                        dir_d  = DIR_UP;
                     end
                  end
               end
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         S_DOOR_OPEN: begin
            // a press for the floor being served just extends the dwell
            abs_car = carCall_i & cur_bit;
            if (dir_q == DIR_UP)   abs_up = up_in & cur_bit;
            if (dir_q == DIR_DOWN) abs_dn = dn_in & cur_bit;
            if (doorHold_i || (|{abs_car, abs_up, abs_dn})) begin
               timer_d = '0;
            end else if (timer_q == OPEN_TC) begin
               timer_d = '0;
               new_dir = pick_dir(dir_q, above, below);
               dir_d   = new_dir;
               state_d = (new_dir == DIR_STOP) ? S_IDLE : S_MOVING;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            dir_d   = DIR_STOP;
            timer_d = '0;
         end
      endcase
      pend_up_d  = (pend_up_q  & ~clr_up)  | (up_in     & ~abs_up);
      pend_dn_d  = (pend_dn_q  & ~clr_dn)  | (dn_in     & ~abs_dn);
      pend_car_d = (pend_car_q & ~clr_car) | (carCall_i & ~abs_car);
   end

   assign currentFloor_o = floor_q;
   assign direction_o    = dir_q;
   assign doorState_o    = (state_q == S_DOOR_OPEN);
   assign move_o         = (state_q == S_MOVING);
   assign pendingUp_o    = pend_up_q;
   assign pendingDown_o  = pend_dn_q;
   assign pendingCar_o   = pend_car_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: fixed vector table, hand-written multi-cycle
// sequences, and a random run against a floor-array reference model.
module tb_elevator_scan_ctrl;
   localparam int F    = 7;
   localparam int OPEN = 4;
   localparam int MOVE = 8;

   logic       clk;
   logic       rst;
   logic [6:0] hu, hd, cc;
   logic       hold;
   logic [3:0] cur_floor;
   logic [1:0] dir;
   logic       door, mv;
   logic [6:0] pu, pd, pc;

   int n_vec = 0;
   int n_err = 0;

   elevator_scan_ctrl #(.FLOORS(F), .CLK_DELAY_OPEN(OPEN), .CLK_DELAY_MOVE(MOVE)) dut (
      .clk_i(clk), .reset_i(rst),
      .hallUp_i(hu), .hallDown_i(hd), .carCall_i(cc), .doorHold_i(hold),
      .currentFloor_o(cur_floor), .direction_o(dir),
      .doorState_o(door), .move_o(mv),
      .pendingUp_o(pu), .pendingDown_o(pd), .pendingCar_o(pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model: one entry per floor number ----------
   int m_floor, m_dir, m_mode, m_left;  // dir +1/-1/0, mode 0 idle 1 door 2 move
   bit m_up [1:F];
   bit m_dn [1:F];
   bit m_car[1:F];

   function automatic bit m_any(input int lo, input int hi);
      bit r = 1'b0;
      for (int f = lo; f <= hi; f++)
         if (f >= 1 && f <= F) r = r | m_up[f] | m_dn[f] | m_car[f];
      return r;
   endfunction

   function automatic int pick(input int d, input bit a, input bit b);
      if (d == -1) return b ? -1 : (a ? 1 : 0);
      return a ? 1 : (b ? -1 : 0);
   endfunction

   task automatic model_step(input bit r, input logic [6:0] u, input logic [6:0] d,
                             input logic [6:0] c, input bit h);
      bit nu[1:F]; bit nd_[1:F]; bit nc[1:F];
      bit cu[1:F]; bit cd[1:F]; bit ccl[1:F];
      bit a, b, ahead, with_dir, against, turn;
      int nd;
      if (r) begin
         m_floor = 1; m_dir = 0; m_mode = 0; m_left = 0;
         for (int f = 1; f <= F; f++) begin
            m_up[f] = 0; m_dn[f] = 0; m_car[f] = 0;
         end
         return;
      end
      for (int f = 1; f <= F; f++) begin
         nu[f]  = u[f-1] && (f != F);
         nd_[f] = d[f-1] && (f != 1);
         nc[f]  = c[f-1];
         cu[f] = 0; cd[f] = 0; ccl[f] = 0;
      end
      a = m_any(m_floor + 1, F);
      b = m_any(1, m_floor - 1);
      case (m_mode)
         0: begin
            if (m_up[m_floor] || m_dn[m_floor] || m_car[m_floor]) begin
               m_mode = 1; m_left = OPEN; ccl[m_floor] = 1;
               if (m_up[m_floor]) begin cu[m_floor] = 1; m_dir = 1; end
               else if (m_dn[m_floor]) begin cd[m_floor] = 1; m_dir = -1; end
               else m_dir = (m_floor == F) ? -1 : 1;
            end else if (a || b) begin
               m_mode = 2; m_left = MOVE; m_dir = pick(0, a, b);
            end
         end
         2: begin
            m_left--;
            if (m_left == 0) begin
               m_floor  = m_floor + m_dir;
               ahead    = (m_dir == 1) ? m_any(m_floor + 1, F) : m_any(1, m_floor - 1);
               with_dir = (m_dir == 1) ? m_up[m_floor] : m_dn[m_floor];
               against  = (m_dir == 1) ? m_dn[m_floor] : m_up[m_floor];
               turn     = against && !ahead && !with_dir;
               if (m_car[m_floor] || with_dir || !ahead) begin
                  m_mode = 1; m_left = OPEN; ccl[m_floor] = 1;
                  if (m_dir == 1) cu[m_floor] = 1; else cd[m_floor] = 1;
                  if (turn) begin
                     if (m_dir == 1) cd[m_floor] = 1; else cu[m_floor] = 1;
                     m_dir = -m_dir;
                  end
               end else begin
                  m_left = MOVE;
               end
            end
         end
         default: begin
            if (nc[m_floor] || (m_dir == 1 && nu[m_floor]) || (m_dir == -1 && nd_[m_floor])) begin
               nc[m_floor] = 0;
               if (m_dir == 1) nu[m_floor] = 0; else nd_[m_floor] = 0;
               m_left = OPEN;
            end else if (h) begin
               m_left = OPEN;
            end else begin
               m_left--;
               if (m_left == 0) begin
                  nd = pick(m_dir, a, b);
                  if (nd == 0) begin m_mode = 0; m_dir = 0; end
                  else begin m_mode = 2; m_dir = nd; m_left = MOVE; end
               end
            end
         end
      endcase
      for (int f = 1; f <= F; f++) begin
         m_up[f]  = (m_up[f]  && !cu[f])  || nu[f];
         m_dn[f]  = (m_dn[f]  && !cd[f])  || nd_[f];
         m_car[f] = (m_car[f] && !ccl[f]) || nc[f];
      end
   endtask

   function automatic logic [28:0] model_vec();
      logic [6:0] a, b, c;
      logic [1:0] dd;
      for (int f = 1; f <= F; f++) begin
         a[f-1] = m_up[f]; b[f-1] = m_dn[f]; c[f-1] = m_car[f];
      end
      dd = (m_dir == 1) ? 2'b10 : ((m_dir == -1) ? 2'b01 : 2'b00);
      return {4'(m_floor), dd, m_mode == 1, m_mode == 2, a, b, c};
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h, required %0h", name, $time, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic [6:0] u, input logic [6:0] d,
                       input logic [6:0] c, input logic h);
      rst = r; hu = u; hd = d; cc = c; hold = h;
      @(posedge clk);
      model_step(r, u, d, c, h);
      #1;
      chk("model", 32'({cur_floor, dir, door, mv, pu, pd, pc}), 32'(model_vec()));
   endtask

   task automatic idle();
      step(1'b0, 7'h0, 7'h0, 7'h0, 1'b0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       rst;
      logic [6:0] hu, hd, cc;
      logic       hold;
      logic [3:0] fl;
      logic [1:0] dir;
      logic       door, mv;
      logic [6:0] pu, pd, pc;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(input logic r, input logic [6:0] u, input logic [6:0] d,
                               input logic [6:0] c, input logic h, input logic [3:0] fl,
                               input logic [1:0] di, input logic dr, input logic m,
                               input logic [6:0] xu, input logic [6:0] xd, input logic [6:0] xc);
      vec_t v;
      v.rst = r; v.hu = u; v.hd = d; v.cc = c; v.hold = h;
      v.fl = fl; v.dir = di; v.door = dr; v.mv = m; v.pu = xu; v.pd = xd; v.pc = xc;
      return v;
   endfunction

   int first_stop, second_stop, nstops, cnt;
   logic [1:0] dir_at2;
   logic [6:0] pd_at2;
   logic prev_door, bad, done;

   initial begin
      //           rst  hu     hd     cc     hold fl    dir    dr mv pu     pd     pc
      tbl[0]  = mk(1, 7'h00, 7'h00, 7'h00, 0, 4'd1, 2'b00, 0, 0, 7'h00, 7'h00, 7'h00);
      tbl[1]  = mk(0, 7'h01, 7'h00, 7'h00, 0, 4'd1, 2'b00, 0, 0, 7'h01, 7'h00, 7'h00);
      tbl[2]  = mk(0, 7'h00, 7'h00, 7'h00, 0, 4'd1, 2'b10, 1, 0, 7'h00, 7'h00, 7'h00);
      tbl[3]  = mk(0, 7'h01, 7'h00, 7'h00, 0, 4'd1, 2'b10, 1, 0, 7'h00, 7'h00, 7'h00);
      tbl[4]  = mk(0, 7'h00, 7'h01, 7'h00, 0, 4'd1, 2'b10, 1, 0, 7'h00, 7'h00, 7'h00);
      tbl[5]  = mk(0, 7'h00, 7'h00, 7'h00, 0, 4'd1, 2'b10, 1, 0, 7'h00, 7'h00, 7'h00);
      tbl[6]  = mk(0, 7'h00, 7'h00, 7'h00, 0, 4'd1, 2'b10, 1, 0, 7'h00, 7'h00, 7'h00);
      tbl[7]  = mk(0, 7'h00, 7'h00, 7'h00, 0, 4'd1, 2'b00, 0, 0, 7'h00, 7'h00, 7'h00);
      tbl[8]  = mk(0, 7'h01, 7'h40, 7'h00, 0, 4'd1, 2'b00, 0, 0, 7'h01, 7'h40, 7'h00);
      tbl[9]  = mk(0, 7'h00, 7'h00, 7'h00, 0, 4'd1, 2'b10, 1, 0, 7'h00, 7'h40, 7'h00);
      tbl[10] = mk(0, 7'h00, 7'h00, 7'h00, 0, 4'd1, 2'b10, 1, 0, 7'h00, 7'h40, 7'h00);
      tbl[11] = mk(0, 7'h00, 7'h00, 7'h00, 0, 4'd1, 2'b10, 1, 0, 7'h00, 7'h40, 7'h00);
      tbl[12] = mk(0, 7'h00, 7'h00, 7'h00, 0, 4'd1, 2'b10, 1, 0, 7'h00, 7'h40, 7'h00);
      tbl[13] = mk(0, 7'h00, 7'h00, 7'h00, 0, 4'd1, 2'b10, 0, 1, 7'h00, 7'h40, 7'h00);
      tbl[14] = mk(1, 7'h00, 7'h00, 7'h10, 0, 4'd1, 2'b00, 0, 0, 7'h00, 7'h00, 7'h00);
      tbl[15] = mk(0, 7'h40, 7'h00, 7'h00, 0, 4'd1, 2'b00, 0, 0, 7'h00, 7'h00, 7'h00);

      for (int i = 0; i < 16; i++) begin
         step(tbl[i].rst, tbl[i].hu, tbl[i].hd, tbl[i].cc, tbl[i].hold);
         chk($sformatf("tbl%0d", i), 32'({cur_floor, dir, door, mv, pu, pd, pc}),
             32'({tbl[i].fl, tbl[i].dir, tbl[i].door, tbl[i].mv, tbl[i].pu, tbl[i].pd, tbl[i].pc}));
      end

      // car call to floor 5: one floor per 8 cycles, 4-cycle dwell, then park
      step(1, 0, 0, 0, 0);
      step(0, 7'h00, 7'h00, 7'h10, 0);
      idle();
      chk("r31_start", 32'({dir, door, mv}), 32'({2'b10, 1'b0, 1'b1}));
      for (int k = 1; k <= 4; k++) begin
         repeat (7) idle();
         chk("r31_hold_floor", 32'(cur_floor), 32'(k));
         idle();
         chk("r31_floor", 32'(cur_floor), 32'(k + 1));
      end
      chk("r31_arrive", 32'({door, mv}), 32'({1'b1, 1'b0}));
      repeat (3) idle();
      chk("r31_dwell", 32'(door), 32'(1));
      idle();
      chk("r31_park", 32'({dir, door, mv, pc}), 32'({2'b00, 1'b0, 1'b0, 7'h00}));

      // door hold for 10 cycles stretches the dwell to 14 cycles
      step(1, 0, 0, 0, 0);
      step(0, 7'h01, 7'h00, 7'h00, 0);
      idle();
      chk("r34_open", 32'(door), 32'(1));
      cnt = 1; bad = 0; done = 0;
      repeat (10) begin
         step(0, 0, 0, 0, 1);
         if (door) cnt++;
         if (mv) bad = 1;
      end
      for (int k = 0; k < 20; k++) begin
         if (!done) begin
            idle();
            if (mv) bad = 1;
            if (door) cnt++; else done = 1;
         end
      end
      chk("r34_open_cycles", 32'(cnt), 32'(14));
      chk("r34_no_move", 32'(bad), 32'(0));

      // going up to 6 passes a down call at 3, then comes back for it
      step(1, 0, 0, 0, 0);
      step(0, 7'h00, 7'h00, 7'h20, 0);
      idle();
      step(0, 7'h00, 7'h04, 7'h00, 0);
      nstops = 0; first_stop = 0; second_stop = 0; prev_door = door;
      dir_at2 = 2'b11; pd_at2 = 7'h7f;
      for (int k = 0; k < 300; k++) begin
         if (nstops < 2) begin
            idle();
            if (door && !prev_door) begin
               nstops++;
               if (nstops == 1) first_stop = cur_floor;
               else begin second_stop = cur_floor; dir_at2 = dir; pd_at2 = pd; end
            end
            prev_door = door;
         end
      end
      chk("r33_stops", 32'(nstops), 32'(2));
      chk("r33_first", 32'(first_stop), 32'(6));
      chk("r33_second", 32'(second_stop), 32'(3));
      chk("r33_dir_down", 32'(dir_at2), 32'(2'b01));
      chk("r33_pd_clear", 32'(pd_at2), 32'(0));

      // reset between floors 3 and 4 discards everything
      step(1, 0, 0, 0, 0);
      step(0, 7'h00, 7'h00, 7'h40, 0);
      for (int k = 0; k < 100; k++) if (cur_floor != 4'd3) idle();
      chk("r36_reached3", 32'(cur_floor), 32'(3));
      step(0, 7'h10, 7'h00, 7'h00, 0);
      idle();
      chk("r36_mid", 32'({cur_floor, mv}), 32'({4'd3, 1'b1}));
      step(1, 7'h00, 7'h00, 7'h01, 0);
      chk("r36_reset", 32'({cur_floor, dir, door, mv, pu, pd, pc}), 32'({4'd1, 25'd0}));

      // random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         logic [6:0] u, d, c;
         logic r, h;
         u = 0; d = 0; c = 0;
         r = ($urandom_range(0, 999) == 0);
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 2))
               0: u[$urandom_range(0, 6)] = 1'b1;
               1: d[$urandom_range(0, 6)] = 1'b1;
               default: c[$urandom_range(0, 6)] = 1'b1;
            endcase
         end
         h = ($urandom_range(0, 24) == 0);
         step(r, u, d, c, h);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
